// File: rtl/cia_pkg.sv
// Shared definitions for the carry-increment adder (CIA) family.
//   CIA_BLK_W : width of one carry-increment slice
//   state_e   : FSM encoding for the digit-serial subtractor
//   nb()      : number of slices needed for a given operand width
package cia_pkg;

  localparam int CIA_BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nb(input int width);
    return width / CIA_BLK_W;
  endfunction

endpackage

// File: rtl/cia_block.sv
// 4-bit carry-increment adder slice.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out
// The low pair of bits ripples with cin. The high pair is summed without any
// carry in, then incremented by the low-pair carry. This keeps the high pair's
// add off the cin path.
module cia_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi_raw;
  logic [2:0] hi_inc;

  always_comb begin
    lo     = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi_raw = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    // The maximum is 3+3+1 = 7, so the carry out still fits in bit 2.
    hi_inc = hi_raw + {2'b00, lo[2]};
    sum    = {hi_inc[1:0], lo[1:0]};
    cout   = hi_inc[2];
  end

endmodule

// File: rtl/cia_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b. It processes one 4-bit slice per clock
// and uses a single cia_block as its datapath.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   a, b                 : minuend and subtrahend, sampled on the handshake
//   out_valid / out_ready: result handshake; out_valid is high in DONE
//   diff                 : a - b modulo 2^WIDTH
//   borrow_out           : a < b (unsigned)
//   overflow             : signed overflow of the subtraction
// Subtraction is a + ~b + 1. The +1 is the carry-in of the first slice. After
// that, each slice's carry out feeds the next slice through carry_q.
module cia_serial_subtractor
  import cia_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NB    = nb(WIDTH);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NB - 1);

  generate
    if (WIDTH % CIA_BLK_W != 0) begin : g_width_check
      $fatal(1, "cia_serial_subtractor: WIDTH must be a multiple of 4");
    end
  endgenerate

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
  logic [WIDTH-1:0]   diff_q,      diff_d;
  logic               sign_a_q,    sign_a_d;
  logic               sign_b_q,    sign_b_d;
  logic               borrow_q,    borrow_d;
  logic               ovf_q,       ovf_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0] slice_sum;
  logic       slice_cout;

  cia_block u_blk (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_d      = diff_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = ~b;
          carry_d    = 1'b1;
          cnt_d      = '0;
          sign_a_d   = a[WIDTH-1];
          sign_b_d   = b[WIDTH-1];
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Slices fill diff from the MSB end. After NB shifts, the first
        // (least significant) slice sits at bits [3:0].
        diff_d  = {slice_sum, diff_q[WIDTH-1:4]};
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          borrow_d    = ~slice_cout;
          // slice_sum[3] is the result's sign bit on the final slice.
          ovf_d       = (sign_a_q != sign_b_q) && (slice_sum[3] != sign_a_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_q      <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_q      <= diff_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cia_serial_subtractor.sv
module tb_cia_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  cia_serial_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_in),
    .b          (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] d, output logic bo, output logic ov);
    int ud;
    int sd;
    ud = int'(x) - int'(y);
    d  = ud[15:0];
    bo = (ud < 0);
    sd = int'($signed(x)) - int'($signed(y));
    ov = (sd > 32767) || (sd < -32768);
  endfunction

  // Drives one operation. Inputs change and outputs are sampled on negedges.
  // lat is the number of edges from the accept edge until out_valid is seen.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       input int pre_gap, input int post_gap, input bit early,
                       output logic [15:0] d, output logic bo, output logic ov,
                       output int lat, output bit to);
    int n;
    to = 0; lat = 0; d = '0; bo = 0; ov = 0;
    repeat (pre_gap) @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin to = 1; return; end
    a_in = ta; b_in = tb_v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
    if (early) out_ready = 1'b1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) begin to = 1; out_ready = 1'b0; return; end
    d = diff; bo = borrow_out; ov = overflow;
    if (!early) begin
      repeat (post_gap) @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 ||
        borrow_out !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bo=%b ov=%b, want 1 0 0000 0 0",
               in_ready, out_valid, diff, borrow_out, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h1234, 16'h1000, 16'h0000, 16'h8000, 16'h7FFF, 16'hA5A5};
    logic [15:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'hA5A5};
    logic [15:0] vd [6] = '{16'h1000, 16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic        vbo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vov[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] d; logic bo, ov; int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], 0, 0, 0, d, bo, ov, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL directed_timeout[%0d]: no handshake", i); continue; end
      n_cmp++;
      if (d !== vd[i] || bo !== vbo[i] || ov !== vov[i]) begin
        n_bad++;
        $display("FAIL directed[%0d] %h-%h: got diff=%h bo=%b ov=%b, want %h %b %b",
                 i, va[i], vb[i], d, bo, ov, vd[i], vbo[i], vov[i]);
      end
      n_cmp++;
      if (lat != 4) begin n_bad++; $display("FAIL latency[%0d]: got %0d edges, want 4", i, lat); end
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL post_handshake[%0d]: out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ed; logic ebo, eov; int n;
    model(16'h4321, 16'h1234, ed, ebo, eov);
    a_in = 16'h4321; b_in = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (!out_valid) begin n_bad++; $display("FAIL backpressure_timeout: out_valid never rose"); return; end
    for (int i = 0; i < 10; i++) begin
      a_in = 16'($urandom); b_in = 16'($urandom); in_valid = i[0];
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed ||
          borrow_out !== ebo || overflow !== eov) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: ov_valid=%b in_ready=%b diff=%h bo=%b ov=%b, want 1 0 %h %b %b",
                 i, out_valid, in_ready, diff, borrow_out, overflow, ed, ebo, eov);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== ed) begin
      n_bad++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b diff=%h, want 0 1 %h",
               out_valid, in_ready, diff, ed);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] d; logic bo, ov; int lat; bit to;
    a_in = 16'hFFFF; b_in = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_run: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_abort[%0d]: out_valid=%b, want 0", i, out_valid);
      end
    end
    do_op(16'd5, 16'd3, 0, 0, 0, d, bo, ov, lat, to);
    n_cmp++;
    if (to || d !== 16'd2 || bo !== 1'b0 || ov !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_op: to=%b diff=%h bo=%b ov=%b, want 0 0002 0 0", to, d, bo, ov);
    end
  endtask

  task automatic test_random(input int n_ops);
    logic [15:0] x, y, d, ed; logic bo, ov, ebo, eov; int lat; bit to;
    for (int i = 0; i < n_ops; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if (i % 16 == 0) y = x;
      if (i % 16 == 1) y = x + 16'd1;
      model(x, y, ed, ebo, eov);
      do_op(x, y, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0), d, bo, ov, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL random_timeout[%0d]", i); return; end
      n_cmp++;
      if (d !== ed || bo !== ebo || ov !== eov) begin
        n_bad++;
        $display("FAIL random[%0d] %h-%h: got diff=%h bo=%b ov=%b, want %h %b %b",
                 i, x, y, d, bo, ov, ed, ebo, eov);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random(4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
